// File: rtl/zpu_sd_pkg.sv
// Shared definitions for the ZPU <-> HPS virtual-disk sector bridge:
// register field positions, slot/fileno mapping and FSM states.
package zpu_sd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int PTR_W        = $clog2(SECTOR_BYTES);

    // zpu_out2 control fields
    localparam int O2_LBA_SEL  = 0;
    localparam int O2_BLOCK_RD = 1;
    localparam int O2_BLOCK_WR = 2;
    localparam int O2_DRV_LO   = 3;
    localparam int O2_DRV_HI   = 5;

    // zpu_in2 status fields
    localparam int I2_IO_DONE     = 0;
    localparam int I2_MOUNTED     = 1;
    localparam int I2_FILENO_LO   = 2;
    localparam int I2_FILETYPE_LO = 5;
    localparam int I2_READONLY    = 7;

    // fileno reported for a mount on slot 0/1/2 (D1, D2, cartridge)
    localparam logic [2:0] FILENO_SLOT0 = 3'd0;
    localparam logic [2:0] FILENO_SLOT1 = 3'd1;
    localparam logic [2:0] FILENO_SLOT2 = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ_RD = 2'd1,
        S_REQ_WR = 2'd2,
        S_XFER   = 2'd3
    } sd_state_e;

endpackage

// File: rtl/zpu_sd_bridge_if.sv
// Bundle of ZPU register and hps_io sd_*/img_* signals seen by the bridge.
// master = firmware/host side, slave = bridge.
interface zpu_sd_bridge_if;
    import zpu_sd_pkg::*;

    logic [31:0]      zpu_out2;
    logic [31:0]      zpu_out3;
    logic             zpu_io_wr;
    logic             zpu_data_wr;
    logic             zpu_data_rd;
    logic [7:0]       zpu_in2;
    logic [31:0]      zpu_in3;

    logic [31:0]      sd_lba;
    logic [2:0]       sd_rd;
    logic [2:0]       sd_wr;
    logic [2:0]       sd_ack;
    logic [PTR_W-1:0] sd_buff_addr;
    logic [7:0]       sd_buff_dout;
    logic             sd_buff_wr;
    logic [7:0]       sd_buff_din;

    logic [2:0]       img_mounted;
    logic             img_readonly;
    logic [63:0]      img_size;
    logic [7:0]       ioctl_index;

    modport master (
        output zpu_out2, zpu_out3, zpu_io_wr, zpu_data_wr, zpu_data_rd,
        input  zpu_in2, zpu_in3,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output img_mounted, img_readonly, img_size, ioctl_index
    );

    modport slave (
        input  zpu_out2, zpu_out3, zpu_io_wr, zpu_data_wr, zpu_data_rd,
        output zpu_in2, zpu_in3,
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  img_mounted, img_readonly, img_size, ioctl_index
    );

endinterface

// File: rtl/sd_sector_buf.sv
// 512x8 dual-port sector RAM, registered read on both ports.
// Port A = host (hps_io), port B = ZPU.
module sd_sector_buf
    import zpu_sd_pkg::*;
(
    input  logic             clk,
    input  logic [PTR_W-1:0] a_addr,
    input  logic [7:0]       a_wdata,
    input  logic             a_we,
    output logic [7:0]       a_rdata,
    input  logic [PTR_W-1:0] b_addr,
    input  logic [7:0]       b_wdata,
    input  logic             b_we,
    output logic [7:0]       b_rdata
);

    logic [7:0] mem [SECTOR_BYTES];

    // Single process so the array has one driver; on an address collision
    // the ZPU write lands last.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/zpu_sd_bridge.sv
// Sector-transfer bridge: ZPU disk-emulation registers <-> hps_io virtual disk
// block interface for D1, D2 and cartridge images.
module zpu_sd_bridge
    import zpu_sd_pkg::*;
#(
    parameter int VDNUM      = 3,
    parameter int TYPE_SHIFT = 6
) (
    input  logic clk_sys,
    input  logic reset_n,
    zpu_sd_bridge_if.slave bus
);

    sd_state_e        state_q, state_d;
    logic [2:0]       sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic             io_done_q, io_done_d;
    logic             blk_rd_q, blk_rd_d, blk_wr_q, blk_wr_d;
    logic             ack_q, ack_d;
    logic [1:0]       dwr_q, dwr_d;
    logic             drd_q, drd_d;
    logic             wr_evt_q, wr_evt_d, wr_lba_q, wr_lba_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [31:0]      sd_lba_q, sd_lba_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             mnt_q, mnt_d, mounted_q, mounted_d;
    logic [2:0]       fileno_q, fileno_d;
    logic [1:0]       filetype_q, filetype_d;
    logic             readonly_q, readonly_d;
    logic [31:0]      filesize_q, filesize_d;

    logic [2:0] drv;
    logic [1:0] slot;
    logic [2:0] slot_oh;
    logic       slot_ok, lba_sel, ack_any, rd_rise, wr_rise, rd_fall, buf_we;
    logic [7:0] buf_q, in2;

    assign drv     = bus.zpu_out2[O2_DRV_HI:O2_DRV_LO];
    assign slot    = {drv[2], drv[0]};
    assign slot_ok = int'(slot) < VDNUM;
    assign lba_sel = bus.zpu_out2[O2_LBA_SEL];
    assign ack_any = |bus.sd_ack;
    assign rd_rise = bus.zpu_out2[O2_BLOCK_RD] & ~blk_rd_q;
    assign wr_rise = bus.zpu_out2[O2_BLOCK_WR] & ~blk_wr_q;
    assign rd_fall = drd_q & ~bus.zpu_data_rd;
    assign buf_we  = wr_evt_q & ~wr_lba_q;

    always_comb begin
        slot_oh = '0;
        for (int i = 0; i < 3; i++) slot_oh[i] = (int'(slot) == i);
    end

    // Request FSM
    always_comb begin
        state_d   = state_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        io_done_d = io_done_q;
        case (state_q)
            S_IDLE: begin
                if (rd_rise && slot_ok) begin
                    state_d   = S_REQ_RD;
                    sd_rd_d   = slot_oh;
                    io_done_d = 1'b0;
                end else if (wr_rise && slot_ok) begin
                    state_d   = S_REQ_WR;
                    sd_wr_d   = slot_oh;
                    io_done_d = 1'b0;
                end
            end
            S_REQ_RD, S_REQ_WR: begin
                if (ack_any) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (ack_q && !ack_any) begin
                    io_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ZPU data path: the write strobe is delayed two stages, its edge is
    // registered with the data, and the LBA/buffer update happens one later.
    always_comb begin
        blk_rd_d  = bus.zpu_out2[O2_BLOCK_RD];
        blk_wr_d  = bus.zpu_out2[O2_BLOCK_WR];
        ack_d     = ack_any;
        dwr_d     = {dwr_q[0], bus.zpu_data_wr};
        wr_evt_d  = dwr_q[0] & ~dwr_q[1];
        wr_lba_d  = lba_sel;
        wr_data_d = bus.zpu_out3;
        drd_d     = bus.zpu_data_rd;
        sd_lba_d  = (wr_evt_q && wr_lba_q) ? wr_data_q : sd_lba_q;
        ptr_d     = ptr_q;
        if (bus.zpu_io_wr)          ptr_d = '0;
        else if (buf_we || rd_fall) ptr_d = ptr_q + 1'b1;
    end

    // Mount event capture
    always_comb begin
        mnt_d      = |bus.img_mounted;
        mounted_d  = mounted_q;
        fileno_d   = fileno_q;
        filetype_d = filetype_q;
        readonly_d = readonly_q;
        filesize_d = filesize_q;
        if (mnt_d && !mnt_q) begin
            mounted_d  = ~mounted_q;
            fileno_d   = bus.img_mounted[2] ? FILENO_SLOT2 :
                         bus.img_mounted[1] ? FILENO_SLOT1 : FILENO_SLOT0;
            filetype_d = bus.ioctl_index[TYPE_SHIFT +: 2];
            readonly_d = bus.img_readonly | bus.img_mounted[2];
            filesize_d = bus.img_size[31:0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sd_rd_q    <= '0;
            sd_wr_q    <= '0;
            io_done_q  <= 1'b1;
            blk_rd_q   <= 1'b0;
            blk_wr_q   <= 1'b0;
            ack_q      <= 1'b0;
            dwr_q      <= '0;
            drd_q      <= 1'b0;
            wr_evt_q   <= 1'b0;
            wr_lba_q   <= 1'b0;
            wr_data_q  <= '0;
            sd_lba_q   <= '0;
            ptr_q      <= '0;
            mnt_q      <= 1'b0;
            mounted_q  <= 1'b0;
            fileno_q   <= '0;
            filetype_q <= '0;
            readonly_q <= 1'b0;
            filesize_q <= '0;
        end else begin
            state_q    <= state_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            io_done_q  <= io_done_d;
            blk_rd_q   <= blk_rd_d;
            blk_wr_q   <= blk_wr_d;
            ack_q      <= ack_d;
            dwr_q      <= dwr_d;
            drd_q      <= drd_d;
            wr_evt_q   <= wr_evt_d;
            wr_lba_q   <= wr_lba_d;
            wr_data_q  <= wr_data_d;
            sd_lba_q   <= sd_lba_d;
            ptr_q      <= ptr_d;
            mnt_q      <= mnt_d;
            mounted_q  <= mounted_d;
            fileno_q   <= fileno_d;
            filetype_q <= filetype_d;
            readonly_q <= readonly_d;
            filesize_q <= filesize_d;
        end
    end

    sd_sector_buf u_buf (
        .clk     (clk_sys),
        .a_addr  (bus.sd_buff_addr),
        .a_wdata (bus.sd_buff_dout),
        .a_we    (bus.sd_buff_wr),
        .a_rdata (bus.sd_buff_din),
        .b_addr  (ptr_q),
        .b_wdata (wr_data_q[7:0]),
        .b_we    (buf_we),
        .b_rdata (buf_q)
    );

    always_comb begin
        in2                                = '0;
        in2[I2_IO_DONE]                    = io_done_q;
        in2[I2_MOUNTED]                    = mounted_q;
        in2[I2_FILENO_LO +: 3]             = fileno_q;
        in2[I2_FILETYPE_LO +: 2]           = filetype_q;
        in2[I2_READONLY]                   = readonly_q;
    end

    assign bus.zpu_in2 = in2;
    assign bus.zpu_in3 = lba_sel ? filesize_q : {24'h0, buf_q};
    assign bus.sd_lba  = sd_lba_q;
    assign bus.sd_rd   = sd_rd_q;
    assign bus.sd_wr   = sd_wr_q;

    logic unused_ok;
    assign unused_ok = ^{bus.zpu_out2[31:O2_DRV_HI+1], bus.img_size[63:32], bus.ioctl_index};

endmodule
